// File: rtl/gf2m_pkg.sv
// Shared constants and FSM encoding for the gf2m digit-serial multiplier front end.
// G163 is the default low part of the 163-bit reduction polynomial.
package gf2m_pkg;
    localparam int DATA_WIDTH     = 163;
    localparam int DIGITAL        = 8;
    localparam int ITN            = (DATA_WIDTH + DIGITAL - 1) / DIGITAL;
    localparam int DATA_WIDTH_BIN = DIGITAL * ITN;
    localparam int TIMEOUT        = 4;

    localparam logic [DATA_WIDTH-1:0] G163 = 163'hC9;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_FEED  = 3'd2,
        ST_WAIT  = 3'd3,
        ST_HOLD  = 3'd4
    } feed_state_e;
endpackage

// File: rtl/gf2m_digit_shreg.sv
// Loadable shift register holding the zero-padded multiplier; presents its top digit
// and moves the next digit up on each shift.
module gf2m_digit_shreg
    import gf2m_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      load_i,
    input  logic                      shift_i,
    input  logic [DATA_WIDTH_BIN-1:0] din_i,
    output logic [DIGITAL-1:0]        digit_o
);
    logic [DATA_WIDTH_BIN-1:0] shreg_q, shreg_d;

    always_comb begin
        shreg_d = shreg_q;
        if (load_i) begin
            shreg_d = din_i;
        end else if (shift_i) begin
            shreg_d = {shreg_q[DATA_WIDTH_BIN-DIGITAL-1:0], {DIGITAL{1'b0}}};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg_q <= '0;
        end else begin
            shreg_q <= shreg_d;
        end
    end

    assign digit_o = shreg_q[DATA_WIDTH_BIN-1 -: DIGITAL];
endmodule

// File: rtl/gf2m_digit_feeder.sv
// Sequencer for the gf2m digit-serial core: start pulse, MSB-first digits, result capture.
// Optional WAIT-state timeout is enabled with the GF2M_FEED_TIMEOUT_EN macro.
module gf2m_digit_feeder
    import gf2m_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_a,
    input  logic [DATA_WIDTH-1:0] in_b,
    input  logic [DATA_WIDTH-1:0] in_g,
    output logic                  core_start,
    output logic [DATA_WIDTH-1:0] core_a,
    output logic [DATA_WIDTH-1:0] core_g,
    output logic [DIGITAL-1:0]    core_b,
    input  logic                  core_done,
    input  logic [DATA_WIDTH-1:0] core_t,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [DATA_WIDTH-1:0] res_data,
    output logic                  res_err,
    output logic [2:0]            dbg_state_o
);
    localparam int CNT_W = $clog2(ITN);

    // Handshakes: a transfer happens on the rising edge where valid and ready are both 1;
    // valid and its data must stay stable until then, and ready never depends on valid.
    feed_state_e           state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] a_q, a_d, g_q, g_d, res_data_q, res_data_d;
    logic                  sh_load, sh_shift, timeout_hit;
    logic [DIGITAL-1:0]    sh_digit;

    gf2m_digit_shreg u_shreg (
        .clk     (clk),
        .rst     (rst),
        .load_i  (sh_load),
        .shift_i (sh_shift),
        .din_i   ({{(DATA_WIDTH_BIN-DATA_WIDTH){1'b0}}, in_b}),
        .digit_o (sh_digit)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        a_d        = a_q;
        g_d        = g_q;
        res_data_d = res_data_q;
        sh_load    = 1'b0;
        sh_shift   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_d     = in_a;
                    g_d     = in_g;
                    sh_load = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_START;
                end
            end
            ST_START: state_d = ST_FEED;
            ST_FEED: begin
                sh_shift = 1'b1;
                if (cnt_q == CNT_W'(ITN-1)) begin
                    cnt_d   = '0;
                    state_d = ST_WAIT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_WAIT: begin
                if (core_done) begin
                    res_data_d = core_t;
                    state_d    = ST_HOLD;
                end else if (timeout_hit) begin
                    res_data_d = '0;
                    state_d    = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (res_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            a_q        <= '0;
            g_q        <= '0;
            res_data_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            a_q        <= a_d;
            g_q        <= g_d;
            res_data_q <= res_data_d;
        end
    end

`ifdef GF2M_FEED_TIMEOUT_EN
    localparam int WAIT_W = $clog2(TIMEOUT + 1);
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              res_err_q, res_err_d;

    // Fires in the TIMEOUT-th WAIT cycle when done still has not arrived.
    assign timeout_hit = (state_q == ST_WAIT) && !core_done && (wait_q == WAIT_W'(TIMEOUT-1));

    always_comb begin
        wait_d    = (state_q == ST_WAIT) ? wait_q + 1'b1 : '0;
        res_err_d = res_err_q;
        if (timeout_hit) begin
            res_err_d = 1'b1;
        end else if ((state_q == ST_HOLD) && res_ready) begin
            res_err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_q    <= '0;
            res_err_q <= 1'b0;
        end else begin
            wait_q    <= wait_d;
            res_err_q <= res_err_d;
        end
    end

    assign res_err = res_err_q;
`else
    assign timeout_hit = 1'b0;
    assign res_err     = 1'b0;
`endif

    assign in_ready    = (state_q == ST_IDLE);
    assign core_start  = (state_q == ST_START);
    assign core_b      = (state_q == ST_FEED) ? sh_digit : '0;
    assign core_a      = a_q;
    assign core_g      = g_q;
    assign res_valid   = (state_q == ST_HOLD);
    assign res_data    = res_data_q;
    assign dbg_state_o = state_q;
endmodule

// File: tb/tb_gf2m_digit_feeder.sv
// Directed bench for gf2m_digit_feeder with a behavioural digit-serial core model.
// Honours GF2M_FEED_TIMEOUT_EN for the no-done scenario.
module tb_gf2m_digit_feeder;
    import gf2m_pkg::*;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  in_valid = 1'b0;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_a = '0, in_b = '0, in_g = '0;
    logic                  core_start;
    logic [DATA_WIDTH-1:0] core_a, core_g;
    logic [DIGITAL-1:0]    core_b;
    logic                  core_done = 1'b0;
    logic [DATA_WIDTH-1:0] core_t = '0;
    logic                  res_valid;
    logic                  res_ready = 1'b0;
    logic [DATA_WIDTH-1:0] res_data;
    logic                  res_err;
    logic [2:0]            dbg_state;

    int n_vec = 0;
    int n_err = 0;
    logic model_silent = 1'b0;

    always #5 clk = ~clk;

    gf2m_digit_feeder dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_g       (in_g),
        .core_start (core_start),
        .core_a     (core_a),
        .core_g     (core_g),
        .core_b     (core_b),
        .core_done  (core_done),
        .core_t     (core_t),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_err    (res_err),
        .dbg_state_o(dbg_state)
    );

    // a*b mod (x^163 + g), MSB-first double-and-add
    function automatic logic [162:0] gf_mul(input logic [162:0] a, input logic [162:0] b,
                                            input logic [162:0] g);
        logic [162:0] acc;
        acc = '0;
        for (int i = 162; i >= 0; i--) begin
            acc = acc[162] ? ({acc[161:0], 1'b0} ^ g) : {acc[161:0], 1'b0};
            if (b[i]) acc = acc ^ a;
        end
        return acc;
    endfunction

    // Core model: collects 21 digits after start, raises done one cycle after the last
    logic [167:0] m_b;
    int           m_cnt;
    logic         m_active;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_active  <= 1'b0;
            m_cnt     <= 0;
            m_b       <= '0;
            core_done <= 1'b0;
            core_t    <= '0;
        end else begin
            core_done <= 1'b0;
            if (core_start) begin
                m_active <= 1'b1;
                m_cnt    <= 0;
                m_b      <= '0;
            end else if (m_active) begin
                m_b   <= {m_b[159:0], core_b};
                m_cnt <= m_cnt + 1;
                if (m_cnt == ITN - 1) begin
                    m_active <= 1'b0;
                    if (!model_silent) begin
                        core_done <= 1'b1;
                        core_t    <= gf_mul(core_a, {m_b[154:0], core_b}, core_g);
                    end
                end
            end
        end
    end

    typedef struct {
        logic [162:0] a;
        logic [162:0] b;
        logic [162:0] g;
        logic [162:0] exp;
        logic [7:0]   d0;
        logic [7:0]   d20;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [167:0] got, input logic [167:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Handshake at E0; on return START is visible
    task automatic start_op(input logic [162:0] a, input logic [162:0] b, input logic [162:0] g);
        check("idle_before_op", in_ready, 1'b1);
        in_a = a; in_b = b; in_g = g;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("start_pulse", core_start, 1'b1);
        check("start_digit_zero", core_b, 8'h00);
        check("busy_after_accept", in_ready, 1'b0);
    endtask

    // Walks the 21 FEED cycles, checking each digit
    task automatic feed_digits(input logic [162:0] b);
        logic [167:0] pad;
        pad = {5'b0, b};
        for (int k = 0; k < ITN; k++) begin
            tick();
            check("digit", core_b, pad[167-8*k -: 8]);
            if (k == 0) check("start_single_cycle", core_start, 1'b0);
        end
    endtask

    task automatic finish_result(input logic [162:0] a, input logic [162:0] g,
                                 input logic [162:0] exp);
        tick();
        check("wait_digit_zero", core_b, 8'h00);
        check("wait_no_valid", res_valid, 1'b0);
        check("core_a_held", core_a, a);
        check("core_g_held", core_g, g);
        tick();
        check("res_valid_e23", res_valid, 1'b1);
        check("res_data", res_data, exp);
        check("res_err_clean", res_err, 1'b0);
    endtask

    task automatic release_result();
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check("released_valid", res_valid, 1'b0);
        check("released_idle", in_ready, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int vcount;
        vecs[0] = '{a: 163'h1, b: 163'h1, g: G163, exp: 163'h1, d0: 8'h00, d20: 8'h01};
        vecs[1] = '{a: 163'h1, b: {163{1'b1}}, g: G163, exp: {163{1'b1}}, d0: 8'h07, d20: 8'hFF};
        vecs[2] = '{a: 163'h3, b: 163'h5, g: G163, exp: 163'hF, d0: 8'h00, d20: 8'h05};
        vecs[3] = '{a: 163'h1 << 162, b: 163'h2, g: G163, exp: 163'hC9, d0: 8'h00, d20: 8'h02};
        vecs[4] = '{a: 163'hF0, b: 163'h100, g: G163, exp: 163'hF000, d0: 8'h00, d20: 8'h00};
        vecs[5] = '{a: 163'h1, b: 163'h1 << 162, g: G163, exp: 163'h1 << 162, d0: 8'h04, d20: 8'h00};
        vecs[6] = '{a: 163'h1 << 160, b: 163'h8, g: G163, exp: 163'hC9, d0: 8'h00, d20: 8'h08};
        vecs[7] = '{a: 163'h1 << 162, b: 163'h2, g: 163'h5, exp: 163'h5, d0: 8'h00, d20: 8'h02};

        // Reset state
        #2;
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_res_valid", res_valid, 1'b0);
        check("rst_core_start", core_start, 1'b0);
        check("rst_core_b", core_b, 8'h00);
        check("rst_core_a", core_a, 163'h0);
        check("rst_core_g", core_g, 163'h0);
        check("rst_res_data", res_data, 163'h0);
        check("rst_res_err", res_err, 1'b0);
        check("rst_state", dbg_state, ST_IDLE);
        @(negedge clk);
        rst = 1'b0;
        tick();
        tick();
        check("post_rst_in_ready", in_ready, 1'b1);
        check("post_rst_res_valid", res_valid, 1'b0);
        check("post_rst_core_start", core_start, 1'b0);
        check("post_rst_core_b", core_b, 8'h00);

        // Table-driven operations
        for (int i = 0; i < 8; i++) begin
            start_op(vecs[i].a, vecs[i].b, vecs[i].g);
            tick();
            check("digit0_table", core_b, vecs[i].d0);
            for (int k = 1; k < ITN; k++) tick();
            check("digit20_table", core_b, vecs[i].d20);
            finish_result(vecs[i].a, vecs[i].g, vecs[i].exp);
            release_result();
        end

        // Backpressure on the result, then back-to-back acceptance timing
        start_op(163'h3, 163'h5, G163);
        feed_digits(163'h5);
        finish_result(163'h3, G163, 163'hF);
        for (int c = 0; c < 10; c++) begin
            tick();
            check("hold_valid", res_valid, 1'b1);
            check("hold_data", res_data, 163'hF);
            check("hold_busy", in_ready, 1'b0);
        end
        in_a = 163'h1; in_b = 163'h1; in_g = G163;
        in_valid = 1'b1;
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check("hold_exit_idle", in_ready, 1'b1);
        check("no_accept_in_hold", core_start, 1'b0);
        tick();
        in_valid = 1'b0;
        check("accept_next_cycle", core_start, 1'b1);
        feed_digits(163'h1);
        finish_result(163'h1, G163, 163'h1);
        release_result();

        // Reset during FEED digit 10 aborts the operation
        start_op(163'h1, {163{1'b1}}, G163);
        for (int k = 0; k <= 10; k++) tick();
        check("digit10_before_abort", core_b, 8'hFF);
        rst = 1'b1;
        #1;
        check("abort_core_start", core_start, 1'b0);
        check("abort_core_b", core_b, 8'h00);
        check("abort_in_ready", in_ready, 1'b1);
        check("abort_res_valid", res_valid, 1'b0);
        tick();
        @(negedge clk);
        rst = 1'b0;
        vcount = 0;
        for (int c = 0; c < 30; c++) begin
            tick();
            if (res_valid) vcount++;
        end
        check("abort_no_result", vcount, 0);
        start_op(163'hF0, 163'h100, G163);
        feed_digits(163'h100);
        finish_result(163'hF0, G163, 163'hF000);
        release_result();

        // Core never answers
        model_silent = 1'b1;
        start_op(163'h3, 163'h5, G163);
        feed_digits(163'h5);
`ifdef GF2M_FEED_TIMEOUT_EN
        for (int c = 0; c < TIMEOUT; c++) begin
            tick();
            check("timeout_not_yet", res_valid, 1'b0);
        end
        tick();
        check("timeout_valid", res_valid, 1'b1);
        check("timeout_err", res_err, 1'b1);
        check("timeout_data", res_data, 163'h0);
        release_result();
        check("timeout_err_cleared", res_err, 1'b0);
`else
        vcount = 0;
        for (int c = 0; c < 50; c++) begin
            tick();
            if (res_valid) vcount++;
        end
        check("no_timeout_no_valid", vcount, 0);
        check("no_timeout_err", res_err, 1'b0);
        check("no_timeout_stuck", in_ready, 1'b0);
        rst = 1'b1;
        tick();
        @(negedge clk);
        rst = 1'b0;
        tick();
        check("recover_idle", in_ready, 1'b1);
`endif
        model_silent = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
